// File: rtl/bsg_dmc_burst_client.sv
// Whole-burst client adapter for the DMC user interface: accepts one cache-line
// read or write request and sequences the app_* command, write-data and read-data ports.

package bsg_dmc_burst_client_pkg;
    typedef enum logic [2:0] {
        WR = 3'b000,
        RD = 3'b001
    } app_cmd_e;
endpackage

module bsg_dmc_burst_client
    import bsg_dmc_burst_client_pkg::*;
#(
    parameter int ui_addr_width_p    = 28,
    parameter int ui_data_width_p    = 32,
    parameter int burst_data_width_p = 128,
    localparam int beats_lp            = burst_data_width_p / ui_data_width_p,
    localparam int ui_mask_width_lp    = ui_data_width_p >> 3,
    localparam int burst_mask_width_lp = burst_data_width_p >> 3
) (
    input  logic                           clk_i,
    input  logic                           reset_i,

    input  logic                           req_v_i,
    input  logic                           req_write_i,
    input  logic [ui_addr_width_p-1:0]     req_addr_i,
    input  logic [burst_data_width_p-1:0]  req_data_i,
    input  logic [burst_mask_width_lp-1:0] req_mask_i,
    output logic                           req_ready_o,

    output logic                           resp_v_o,
    output logic [burst_data_width_p-1:0]  resp_data_o,
    input  logic                           resp_yumi_i,

    output logic [ui_addr_width_p-1:0]     app_addr_o,
    output app_cmd_e                       app_cmd_o,
    output logic                           app_en_o,
    input  logic                           app_rdy_i,
    output logic                           app_wdf_wren_o,
    output logic [ui_data_width_p-1:0]     app_wdf_data_o,
    output logic [ui_mask_width_lp-1:0]    app_wdf_mask_o,
    output logic                           app_wdf_end_o,
    input  logic                           app_wdf_rdy_i,
    input  logic                           app_rd_data_valid_i,
    input  logic [ui_data_width_p-1:0]     app_rd_data_i,
    input  logic                           app_rd_data_end_i,

    output logic                           busy_o
);

    localparam int cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam logic [cnt_width_lp-1:0] last_cnt_lp = cnt_width_lp'(beats_lp - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WDATA = 3'd2,
        RWAIT = 3'd3,
        RESP  = 3'd4
    } state_e;

    state_e state_r, state_n_s;

    logic                                            write_r;
    logic [ui_addr_width_p-1:0]                      addr_r;
    logic [beats_lp-1:0][ui_data_width_p-1:0]        data_r;
    logic [beats_lp-1:0][ui_mask_width_lp-1:0]       mask_r;
    logic [beats_lp-1:0][ui_data_width_p-1:0]        rdata_r;
    logic [cnt_width_lp-1:0]                         cnt_r;

    logic accept_s, cmd_done_s, wbeat_s, rbeat_s, last_beat_s;

    // Read-beat framing is done by counting; the end marker is not needed.
    logic unused_rd_end_s;
    assign unused_rd_end_s = app_rd_data_end_i;

    assign last_beat_s = (cnt_r == last_cnt_lp);

    // Handshake strobes qualified by the current state
    always_comb begin
        accept_s   = (state_r == IDLE)  && req_v_i;
        cmd_done_s = (state_r == CMD)   && app_rdy_i;
        wbeat_s    = (state_r == WDATA) && app_wdf_rdy_i;
        rbeat_s    = (state_r == RWAIT) && app_rd_data_valid_i;
    end

    // Next-state logic
    always_comb begin
        state_n_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_v_i) state_n_s = CMD;
                else         state_n_s = IDLE;
            end
            CMD: begin
                if (app_rdy_i) state_n_s = write_r ? WDATA : RWAIT;
                else           state_n_s = CMD;
            end
            WDATA: begin
                if (app_wdf_rdy_i && last_beat_s) state_n_s = IDLE;
                else                              state_n_s = WDATA;
            end
            RWAIT: begin
                if (app_rd_data_valid_i && last_beat_s) state_n_s = RESP;
                else                                    state_n_s = RWAIT;
            end
            RESP: begin
                if (resp_yumi_i) state_n_s = IDLE;
                else             state_n_s = RESP;
            end
            default: state_n_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= IDLE;
        else         state_r <= state_n_s;
    end

    // Request capture, beat counter and read-burst assembly
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            write_r <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
            mask_r  <= '0;
            rdata_r <= '0;
            cnt_r   <= '0;
        end else begin
            if (accept_s) begin
                write_r <= req_write_i;
                addr_r  <= req_addr_i;
                data_r  <= req_data_i;
                mask_r  <= req_mask_i;
            end
            // Counter returns to zero on the last beat so it never wraps
            if (cmd_done_s) begin
                cnt_r <= '0;
            end else if (wbeat_s || rbeat_s) begin
                cnt_r <= last_beat_s ? '0 : cnt_r + cnt_width_lp'(1);
            end
            if (rbeat_s) begin
                rdata_r[cnt_r] <= app_rd_data_i;
            end
        end
    end

    // Control outputs decoded from registered state only
    always_comb begin
        req_ready_o    = 1'b0;
        busy_o         = 1'b1;
        app_en_o       = 1'b0;
        app_cmd_o      = WR;
        app_wdf_wren_o = 1'b0;
        app_wdf_end_o  = 1'b0;
        resp_v_o       = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            CMD: begin
                app_en_o  = 1'b1;
                app_cmd_o = write_r ? WR : RD;
            end
            WDATA: begin
                app_wdf_wren_o = 1'b1;
                app_wdf_end_o  = last_beat_s;
            end
            RWAIT: begin
                busy_o = 1'b1;
            end
            RESP: begin
                resp_v_o = 1'b1;
            end
            default: begin
                busy_o = 1'b1;
            end
        endcase
    end

    assign app_addr_o     = addr_r;
    assign app_wdf_data_o = data_r[cnt_r];
    assign app_wdf_mask_o = mask_r[cnt_r];
    assign resp_data_o    = rdata_r;

endmodule

// File: tb/tb_bsg_dmc_burst_client.sv
// Randomized self-checking bench for bsg_dmc_burst_client: a byte-addressed line
// memory behind a stalling UI model, checked against a request-level scoreboard.

module tb_bsg_dmc_burst_client;
    import bsg_dmc_burst_client_pkg::*;

    localparam int AW = 28;
    localparam int DW = 32;
    localparam int BW = 128;
    localparam int NB = BW / DW;
    localparam int MW = BW / 8;

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b1;
    logic            req_v_i, req_write_i, req_ready_o;
    logic [AW-1:0]   req_addr_i;
    logic [BW-1:0]   req_data_i;
    logic [MW-1:0]   req_mask_i;
    logic            resp_v_o, resp_yumi_i;
    logic [BW-1:0]   resp_data_o;
    logic [AW-1:0]   app_addr_o;
    app_cmd_e        app_cmd_o;
    logic            app_en_o, app_rdy_i, app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
    logic [DW-1:0]   app_wdf_data_o, app_rd_data_i;
    logic [DW/8-1:0] app_wdf_mask_o;
    logic            app_rd_data_valid_i, app_rd_data_end_i, busy_o;

    bsg_dmc_burst_client #(
        .ui_addr_width_p(AW), .ui_data_width_p(DW), .burst_data_width_p(BW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req_v_i(req_v_i), .req_write_i(req_write_i), .req_addr_i(req_addr_i),
        .req_data_i(req_data_i), .req_mask_i(req_mask_i), .req_ready_o(req_ready_o),
        .resp_v_o(resp_v_o), .resp_data_o(resp_data_o), .resp_yumi_i(resp_yumi_i),
        .app_addr_o(app_addr_o), .app_cmd_o(app_cmd_o), .app_en_o(app_en_o),
        .app_rdy_i(app_rdy_i), .app_wdf_wren_o(app_wdf_wren_o),
        .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
        .app_wdf_end_o(app_wdf_end_o), .app_wdf_rdy_i(app_wdf_rdy_i),
        .app_rd_data_valid_i(app_rd_data_valid_i), .app_rd_data_i(app_rd_data_i),
        .app_rd_data_end_i(app_rd_data_end_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    // UI inputs come either from the directed script or from the random UI model
    logic          ui_auto = 1'b0;
    logic          man_rdy = 1'b0, man_wdf_rdy = 1'b0, man_rv = 1'b0, man_yumi = 1'b0;
    logic [DW-1:0] man_rdata = '0;
    logic          auto_rdy, auto_wdf_rdy, auto_rv, auto_yumi;
    logic [DW-1:0] auto_rdata;

    assign app_rdy_i           = ui_auto ? auto_rdy     : man_rdy;
    assign app_wdf_rdy_i       = ui_auto ? auto_wdf_rdy : man_wdf_rdy;
    assign app_rd_data_valid_i = ui_auto ? auto_rv      : man_rv;
    assign app_rd_data_i       = ui_auto ? auto_rdata   : man_rdata;
    assign resp_yumi_i         = ui_auto ? auto_yumi    : man_yumi;
    assign app_rd_data_end_i   = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] line_init(input logic [AW-1:0] a);
        return {4{4'hA, a}};
    endfunction

    function automatic logic [BW-1:0] merge(input logic [BW-1:0] old, input logic [BW-1:0] nw,
                                            input logic [MW-1:0] m);
        logic [BW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++) if (!m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
        return r;
    endfunction

    // Reference model: line memory updated per request, expected traffic queues
    logic [BW-1:0]  ref_mem [logic [AW-1:0]];
    logic [AW:0]    exp_cmd_q [$];
    logic [36:0]    exp_wbeat_q [$];
    logic [BW-1:0]  exp_resp_q [$];

    // UI-side memory, built only from beats the DUT actually wrote
    logic [BW-1:0]  ui_mem [logic [AW-1:0]];
    logic [DW-1:0]  rd_beats [$];
    logic [AW-1:0]  waddr;
    logic [BW-1:0]  acc_data, line;
    logic [MW-1:0]  acc_mask;
    int             wb = 0;

    initial begin : ui_model
        auto_rdy = 1'b0; auto_wdf_rdy = 1'b0; auto_rv = 1'b0; auto_rdata = '0; auto_yumi = 1'b0;
        acc_data = '0; acc_mask = '0; waddr = '0;
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                wb = 0;
                rd_beats.delete();
            end else begin
                if (app_en_o && app_rdy_i) begin
                    if (app_cmd_o == WR) begin
                        waddr = app_addr_o;
                    end else if (ui_auto) begin
                        line = ui_mem.exists(app_addr_o) ? ui_mem[app_addr_o] : line_init(app_addr_o);
                        for (int k = 0; k < NB; k++) rd_beats.push_back(line[k*DW +: DW]);
                    end
                end
                if (app_wdf_wren_o && app_wdf_rdy_i) begin
                    acc_data[(wb%NB)*DW +: DW]     = app_wdf_data_o;
                    acc_mask[(wb%NB)*DW/8 +: DW/8] = app_wdf_mask_o;
                    wb++;
                    if (app_wdf_end_o) begin
                        ui_mem[waddr] = merge(ui_mem.exists(waddr) ? ui_mem[waddr] : line_init(waddr),
                                              acc_data, acc_mask);
                        wb = 0;
                    end
                end
            end
            @(posedge clk_i); #1;
            auto_rdy     = ($urandom_range(0, 3) != 0);
            auto_wdf_rdy = ($urandom_range(0, 3) != 0);
            if (rd_beats.size() > 0 && $urandom_range(0, 2) != 0) begin
                auto_rv    = 1'b1;
                auto_rdata = rd_beats.pop_front();
            end else begin
                auto_rv    = (rd_beats.size() == 0) && ($urandom_range(0, 15) == 0);
                auto_rdata = $urandom;
            end
            auto_yumi = resp_v_o && ($urandom_range(0, 2) == 0);
        end
    end

    // Protocol monitor: traffic vs. expectations, hold stability, reset values
    logic          cmd_hold = 1'b0, wd_hold = 1'b0, resp_hold = 1'b0;
    logic [AW+2:0] cmd_held;
    logic [36:0]   wd_held;
    logic [BW-1:0] resp_held;

    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (reset_i) begin
                check("rst_ctrl", {req_ready_o, resp_v_o, app_en_o, app_cmd_o, app_wdf_wren_o,
                                   app_wdf_end_o, app_wdf_mask_o, busy_o}, {1'b1, 12'h000});
                check("rst_data", {app_addr_o, app_wdf_data_o}, '0);
                check("rst_resp", resp_data_o, '0);
                exp_cmd_q.delete(); exp_wbeat_q.delete(); exp_resp_q.delete();
                cmd_hold = 1'b0; wd_hold = 1'b0; resp_hold = 1'b0;
            end else begin
                check("ready_vs_busy", req_ready_o & busy_o, 1'b0);
                if (cmd_hold)  check("cmd_stable", {app_en_o, app_cmd_o, app_addr_o}, {1'b1, cmd_held});
                if (wd_hold)   check("wdata_stable", {app_wdf_wren_o, app_wdf_end_o, app_wdf_mask_o,
                                                      app_wdf_data_o}, {1'b1, wd_held});
                if (resp_hold) begin
                    check("resp_v_stable", resp_v_o, 1'b1);
                    check("resp_data_stable", resp_data_o, resp_held);
                end
                if (app_en_o && app_rdy_i) begin
                    if (exp_cmd_q.size() == 0) check("cmd_unexpected", app_en_o, 1'b0);
                    else begin
                        logic [AW:0] e;
                        e = exp_cmd_q.pop_front();
                        check("cmd", {app_cmd_o, app_addr_o}, {(e[AW] ? WR : RD), e[AW-1:0]});
                    end
                end
                if (app_wdf_wren_o && app_wdf_rdy_i) begin
                    if (exp_wbeat_q.size() == 0) check("wbeat_unexpected", app_wdf_wren_o, 1'b0);
                    else check("wbeat", {app_wdf_end_o, app_wdf_mask_o, app_wdf_data_o},
                               exp_wbeat_q.pop_front());
                end
                if (resp_v_o && resp_yumi_i) begin
                    if (exp_resp_q.size() == 0) check("resp_unexpected", resp_v_o, 1'b0);
                    else check("resp_data", resp_data_o, exp_resp_q.pop_front());
                end
                cmd_hold  = app_en_o && !app_rdy_i;
                cmd_held  = {app_cmd_o, app_addr_o};
                wd_hold   = app_wdf_wren_o && !app_wdf_rdy_i;
                wd_held   = {app_wdf_end_o, app_wdf_mask_o, app_wdf_data_o};
                resp_hold = resp_v_o && !resp_yumi_i;
                resp_held = resp_data_o;
            end
        end
    end

    task automatic step();
        @(posedge clk_i); #1;
    endtask

    // Record expectations for one request, then present it until accepted
    task automatic issue(input bit wr, input logic [AW-1:0] a, input logic [BW-1:0] d,
                         input logic [MW-1:0] m);
        logic [BW-1:0] cur;
        cur = ref_mem.exists(a) ? ref_mem[a] : line_init(a);
        exp_cmd_q.push_back({wr, a});
        if (wr) begin
            for (int k = 0; k < NB; k++)
                exp_wbeat_q.push_back({(k == NB-1), m[k*DW/8 +: DW/8], d[k*DW +: DW]});
            ref_mem[a] = merge(cur, d, m);
        end else begin
            exp_resp_q.push_back(cur);
        end
        req_v_i = 1'b1; req_write_i = wr; req_addr_i = a; req_data_i = d; req_mask_i = m;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_i);
            if (req_ready_o) break;
        end
        check("accept", req_ready_o, 1'b1);
        step();
        req_v_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (!busy_o && exp_cmd_q.size() == 0 && exp_wbeat_q.size() == 0 && exp_resp_q.size() == 0)
                break;
        end
        check("drain", {busy_o, exp_cmd_q.size() != 0, exp_wbeat_q.size() != 0,
                        exp_resp_q.size() != 0}, 4'h0);
        step();
    endtask

    logic [DW-1:0] rv_data [7] = '{32'hA, 32'h0, 32'hB, 32'h0, 32'h0, 32'hC, 32'hD};
    logic          rv_en   [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin : main
        int acc;
        req_v_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_data_i = '0; req_mask_i = '0;
        ref_mem[28'h80] = 128'h0000000D_0000000C_0000000B_0000000A;
        repeat (3) @(posedge clk_i);
        #1 reset_i = 1'b0;

        // Fastest write: exact cycle positions of command, beats and ready
        man_rdy = 1'b1; man_wdf_rdy = 1'b1;
        issue(1'b1, 28'h40, 128'h33333333_22222222_11111111_00000000, '0);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk_i);
            check("fast_en", app_en_o, (c == 1));
            check("fast_wren", app_wdf_wren_o, (c >= 2 && c <= 5));
            check("fast_ready", req_ready_o, (c == 6));
            step();
        end

        // Stalled command and toggling write-data ready
        man_rdy = 1'b0; man_wdf_rdy = 1'b0;
        issue(1'b1, 28'h44, {$urandom, $urandom, $urandom, $urandom}, 16'hF0F0);
        for (int c = 0; c < 4; c++) begin
            man_rdy = (c == 3);
            @(negedge clk_i);
            check("cmd_held_en", app_en_o, 1'b1);
            step();
        end
        man_rdy = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            man_wdf_rdy = (i % 2 == 0);
            @(negedge clk_i);
            if (app_wdf_wren_o && app_wdf_rdy_i) acc++;
            step();
        end
        check("wbeat_count", acc, 4);
        check("stall_write_idle", busy_o, 1'b0);
        man_wdf_rdy = 1'b0;

        // Spurious read-valid in IDLE and CMD, then a gapped read
        man_rv = 1'b1; man_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            check("idle_spurious", busy_o, 1'b0);
            step();
        end
        issue(1'b0, 28'h80, '0, '0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            check("cmd_spurious", app_en_o, 1'b1);
            step();
        end
        man_rv = 1'b0; man_rdy = 1'b1;
        step();
        man_rdy = 1'b0;
        for (int i = 0; i < 7; i++) begin
            man_rv = rv_en[i]; man_rdata = rv_data[i];
            @(negedge clk_i);
            check("rwait_no_resp", resp_v_o, 1'b0);
            step();
        end
        man_rv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("resp_held_v", resp_v_o, 1'b1);
            check("resp_held_data", resp_data_o, 128'h0000000D_0000000C_0000000B_0000000A);
            step();
        end
        man_yumi = 1'b1;
        step();
        man_yumi = 1'b0;
        @(negedge clk_i);
        check("read_idle", busy_o, 1'b0);
        step();

        // Reset in the middle of a write, then a normal read
        man_rdy = 1'b1; man_wdf_rdy = 1'b1;
        issue(1'b1, 28'h100, {$urandom, $urandom, $urandom, $urandom}, '0);
        repeat (3) step();
        reset_i = 1'b1;
        man_rdy = 1'b0; man_wdf_rdy = 1'b0;
        repeat (2) step();
        reset_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("post_rst_wren", {app_wdf_wren_o, busy_o}, 2'b00);
            step();
        end
        ui_auto = 1'b1;
        issue(1'b0, 28'h300, '0, '0);
        wait_done();

        // Random back-to-back mix
        for (int n = 0; n < 200; n++) begin
            logic [MW-1:0] m;
            m = ($urandom_range(0, 1) == 0) ? '0 : MW'($urandom);
            issue($urandom_range(0, 1) == 1, 28'h200 + 28'(16 * $urandom_range(0, 7)),
                  {$urandom, $urandom, $urandom, $urandom}, m);
        end
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
